mem_access: RTL and testbench
=============================

// Module: mem_access
// PURPOSE
//  MEM-stage data-access unit, directly downstream of the execute stage.
//  Takes EX/MEM-registered ALU result (address) and rt data (store data), raises
//  load/store address-error exceptions, drives a SRAM-like data bus (req/addr_ok/data_ok),
//  aligns/sign-extends load data. Stalls the pipeline while a transaction is outstanding.
// PARAMETERS
//  AW  32  address width
//  DW  32  data width (fixed 32; byte lanes = DW/8)
// PORTS
//  clk           in   1   clock
//  rst           in   1   synchronous, active-high reset
//  m_valid       in   1   MEM-stage instruction valid
//  m_mem_op      in   4   mem_op_t: NONE,LB,LBU,LH,LHU,LW,SB,SH,SW
//  m_addr        in   32  effective address (EX ex_out)
//  m_wdata       in   32  store data (EX rtdata)
//  m_flush       in   1   exception/eret flush of MEM stage
//  data_req      out  1   bus request
//  data_wr       out  1   1=store, 0=load
//  data_size     out  2   0=byte,1=half,2=word
//  data_addr     out  32  bus address (unmodified m_addr)
//  data_wdata    out  32  lane-replicated store data
//  data_addr_ok  in   1   request accepted
//  data_data_ok  in   1   read data valid / write complete
//  data_rdata    in   32  raw bus read data
//  m_rdata       out  32  aligned, extended load result
//  m_done        out  1   1-cycle pulse: access complete, m_rdata valid
//  m_stall       out  1   hold MEM and all older stages
//  m_adel        out  1   load address error
//  m_ades        out  1   store address error
//  m_badvaddr    out  32  faulting address (= m_addr when adel/ades)
// BEHAVIOUR
//  Reset: state=IDLE; data_req,m_done,m_stall,m_adel,m_ades=0; m_rdata,data_* regs=0.
//  Addr error (combinational): LH/LHU addr[0]!=0, LW addr[1:0]!=0 -> adel; SH/SW same -> ades.
//   Only when m_valid. Faulting op never issues a bus request.
//  FSM states IDLE, REQ, WAIT, DONE; discard flag drop.
//   IDLE: m_valid & op!=NONE & !err & !m_flush -> latch addr/size/wr/wdata, REQ.
//   REQ : data_req=1, bus fields held stable; addr_ok & data_ok same cycle -> DONE
//         (or IDLE if drop); addr_ok only -> WAIT.
//   WAIT: data_ok -> latch data_rdata, DONE (or IDLE if drop).
//   DONE: m_done=1 for exactly one cycle, m_stall=0 -> IDLE.
//  m_stall = (IDLE & issuing) | REQ | WAIT. Min load latency: issue cycle + REQ + DONE = 3 cycles.
//  Flush: in IDLE suppresses issue. In REQ/WAIT the request is NOT withdrawn (req held until
//   addr_ok); drop=1, response absorbed, no m_done, m_stall held until return to IDLE.
//  Store data: SB {4{wdata[7:0]}}, SH {2{wdata[15:0]}}, SW as-is.
//  Load: select lane by addr[1:0] (byte) / addr[1] (half); LB/LH sign-extend, LBU/LHU zero-extend.
//  m_rdata holds last value until next DONE. data_ok while IDLE is ignored.
//  Reset mid-transaction: return to IDLE, drop outstanding response.
// STRUCTURE
//  cpu_defs.svh: mem_op_t enum, mem_state_t enum, SIZE_BYTE/HALF/WORD constants.
//  Sub-module load_align (comb): op, addr[1:0], raw -> extended word; reusable for uncached path.
// TESTING
//  LW addr=0x80000010, addr_ok+data_ok same cycle, rdata=0x12345678 -> m_done cycle 3, m_rdata=0x12345678.
//  LB addr=..13, rdata=0x80FFFFFF -> 0xFFFFFF80; LBU same -> 0x00000080; LHU addr ..12 -> 0x000080FF.
//  SH addr=..02, wdata=0xAAAABEEF -> data_wr=1, size=1, data_wdata=0xBEEFBEEF.
//  LW addr=0x...2 -> m_adel=1, m_badvaddr=addr, data_req never asserted, m_stall=0.
//  addr_ok delayed 3 cycles: req/addr/wdata stable throughout, m_stall=1 until m_done.
//  m_flush during WAIT, data_ok 2 cycles later -> no m_done, m_stall low after absorb, next op issues normally.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared types and helpers for the MEM-stage data-access unit.
// Covers operation and state encodings, bus size codes, and lane/alignment helpers.
package mem_access_pkg;

  typedef enum logic [3:0] {
    MOP_NONE = 4'd0,
    MOP_LB   = 4'd1,
    MOP_LBU  = 4'd2,
    MOP_LH   = 4'd3,
    MOP_LHU  = 4'd4,
    MOP_LW   = 4'd5,
    MOP_SB   = 4'd6,
    MOP_SH   = 4'd7,
    MOP_SW   = 4'd8
  } mem_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } mem_state_t;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  function automatic logic op_is_store(mem_op_t op);
    return (op == MOP_SB) || (op == MOP_SH) || (op == MOP_SW);
  endfunction

  function automatic logic [1:0] op_size(mem_op_t op);
    logic [1:0] sz;
    case (op)
      MOP_LB, MOP_LBU, MOP_SB: sz = SIZE_BYTE;
      MOP_LH, MOP_LHU, MOP_SH: sz = SIZE_HALF;
      default:                 sz = SIZE_WORD;
    endcase
    return sz;
  endfunction

  // Halfword accesses need addr[0]==0, word accesses need addr[1:0]==0.
  function automatic logic addr_misaligned(mem_op_t op, logic [1:0] lo);
    logic bad;
    case (op)
      MOP_LH, MOP_LHU, MOP_SH: bad = lo[0];
      MOP_LW, MOP_SW:          bad = |lo;
      default:                 bad = 1'b0;
    endcase
    return bad;
  endfunction

  function automatic logic [31:0] store_lanes(mem_op_t op, logic [31:0] w);
    logic [31:0] r;
    case (op)
      MOP_SB:  r = {4{w[7:0]}};
      MOP_SH:  r = {2{w[15:0]}};
      default: r = w;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_access_if.sv
// SRAM-like data bus between the MEM-stage access unit (master) and memory (slave).
interface mem_access_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          data_req;
  logic          data_wr;
  logic [1:0]    data_size;
  logic [AW-1:0] data_addr;
  logic [DW-1:0] data_wdata;
  logic          data_addr_ok;
  logic          data_data_ok;
  logic [DW-1:0] data_rdata;

  modport master (
    output data_req,
    output data_wr,
    output data_size,
    output data_addr,
    output data_wdata,
    input  data_addr_ok,
    input  data_data_ok,
    input  data_rdata
  );

  modport slave (
    input  data_req,
    input  data_wr,
    input  data_size,
    input  data_addr,
    input  data_wdata,
    output data_addr_ok,
    output data_data_ok,
    output data_rdata
  );
endinterface

// File: rtl/mem_access_load_align.sv
// Combinational load alignment: picks the addressed byte/half lane from a raw bus
// word and sign- or zero-extends it. Stateless so it can be reused on other load paths.
module load_align
  import mem_access_pkg::*;
(
  input  mem_op_t     op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] raw,
  output logic [31:0] result
);

  logic [7:0]  lane [4];
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign lane[gi] = raw[gi*8 +: 8];
  end

  always_comb begin
    byte_sel = lane[addr_lo];
    half_sel = addr_lo[1] ? raw[31:16] : raw[15:0];
    case (op)
      MOP_LB:  result = {{24{byte_sel[7]}}, byte_sel};
      MOP_LBU: result = {24'd0, byte_sel};
      MOP_LH:  result = {{16{half_sel[15]}}, half_sel};
      MOP_LHU: result = {16'd0, half_sel};
      default: result = raw;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// MEM-stage data-access unit: flags misaligned accesses, runs one bus transaction at a
// time over the req/addr_ok/data_ok bus, and stalls older stages while it is outstanding.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m_valid,
  input  mem_op_t       m_mem_op,
  input  logic [AW-1:0] m_addr,
  input  logic [DW-1:0] m_wdata,
  input  logic          m_flush,
  mem_access_if.master  bus,
  output logic [DW-1:0] m_rdata,
  output logic          m_done,
  output logic          m_stall,
  output logic          m_adel,
  output logic          m_ades,
  output logic [AW-1:0] m_badvaddr
);

  mem_state_t    state_q, state_d;
  logic          drop_q, drop_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [1:0]    size_q, size_d;
  logic          wr_q, wr_d;
  mem_op_t       op_q, op_d;
  logic [DW-1:0] rdata_q, rdata_d;

  logic          misaligned;
  logic          issue;
  logic          discard;
  logic [31:0]   aligned;

  load_align u_load_align (
    .op      (op_q),
    .addr_lo (addr_q[1:0]),
    .raw     (bus.data_rdata),
    .result  (aligned)
  );

  // Address errors are judged on the live MEM-stage inputs, not the latched request.
  always_comb begin
    misaligned = m_valid && addr_misaligned(m_mem_op, m_addr[1:0]);
    m_adel     = misaligned && !op_is_store(m_mem_op);
    m_ades     = misaligned && op_is_store(m_mem_op);
    m_badvaddr = misaligned ? m_addr : '0;
    issue      = (state_q == ST_IDLE) && m_valid && (m_mem_op != MOP_NONE)
                 && !misaligned && !m_flush;
  end

  always_comb begin
    state_d = state_q;
    drop_d  = drop_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    size_d  = size_q;
    wr_d    = wr_q;
    op_d    = op_q;
    rdata_d = rdata_q;
    // A flush arriving on the completion cycle also discards the response.
    discard = drop_q || m_flush;

    case (state_q)
      ST_IDLE: begin
        if (issue) begin
          addr_d  = m_addr;
          wdata_d = store_lanes(m_mem_op, m_wdata);
          size_d  = op_size(m_mem_op);
          wr_d    = op_is_store(m_mem_op);
          op_d    = m_mem_op;
          drop_d  = 1'b0;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (m_flush) drop_d = 1'b1;
        if (bus.data_addr_ok && bus.data_data_ok) begin
          if (!discard && !wr_q) rdata_d = aligned;
          drop_d  = 1'b0;
          state_d = discard ? ST_IDLE : ST_DONE;
        end else if (bus.data_addr_ok) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (m_flush) drop_d = 1'b1;
        if (bus.data_data_ok) begin
          if (!discard && !wr_q) rdata_d = aligned;
          drop_d  = 1'b0;
          state_d = discard ? ST_IDLE : ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      drop_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= 2'd0;
      wr_q    <= 1'b0;
      op_q    <= MOP_NONE;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      wr_q    <= wr_d;
      op_q    <= op_d;
      rdata_q <= rdata_d;
    end
  end

  // Bus fields come straight from the latched request so they stay stable until addr_ok.
  assign bus.data_req   = (state_q == ST_REQ);
  assign bus.data_wr    = wr_q;
  assign bus.data_size  = size_q;
  assign bus.data_addr  = addr_q;
  assign bus.data_wdata = wdata_q;

  assign m_rdata = rdata_q;
  assign m_done  = (state_q == ST_DONE);
  assign m_stall = issue || (state_q == ST_REQ) || (state_q == ST_WAIT);

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: loads, stores, address errors, bus back-pressure,
// flush while a response is outstanding, and reset in the middle of a transaction.
module tb_mem_access;
  import mem_access_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        m_valid;
  mem_op_t     m_mem_op;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_flush;
  logic [31:0] m_rdata;
  logic        m_done;
  logic        m_stall;
  logic        m_adel;
  logic        m_ades;
  logic [31:0] m_badvaddr;

  int errors = 0;
  int checks = 0;
  logic [31:0] last_rdata = 32'h0;

  mem_access_if #(.AW(32), .DW(32)) bus ();

  mem_access #(.AW(32), .DW(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .m_valid    (m_valid),
    .m_mem_op   (m_mem_op),
    .m_addr     (m_addr),
    .m_wdata    (m_wdata),
    .m_flush    (m_flush),
    .bus        (bus),
    .m_rdata    (m_rdata),
    .m_done     (m_done),
    .m_stall    (m_stall),
    .m_adel     (m_adel),
    .m_ades     (m_ades),
    .m_badvaddr (m_badvaddr)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1; m_valid = 1'b0; m_mem_op = MOP_NONE; m_addr = '0; m_wdata = '0; m_flush = 1'b0;
    bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0; bus.data_rdata = '0;
    repeat (3) @(negedge clk);
    checks++; if (bus.data_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", bus.data_req); end
    checks++; if (m_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", m_done); end
    checks++; if (m_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", m_stall); end
    checks++; if ({m_adel, m_ades} !== 2'b00) begin errors++; $display("FAIL reset_err: got %b want 00", {m_adel, m_ades}); end
    checks++; if (m_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", m_rdata); end
    checks++; if ({bus.data_addr, bus.data_wdata} !== 64'h0) begin errors++; $display("FAIL reset_bus: got %h/%h want 0/0", bus.data_addr, bus.data_wdata); end
    rst = 1'b0;
    $display("txn reset done");
  endtask

  task automatic test_lw();
    @(negedge clk);
    m_valid = 1'b1; m_mem_op = MOP_LW; m_addr = 32'h80000010;
    #1;
    checks++; if (m_stall !== 1'b1) begin errors++; $display("FAIL lw_issue_stall: got %b want 1", m_stall); end
    @(negedge clk);  // REQ
    m_valid = 1'b0; m_mem_op = MOP_NONE; m_addr = '0;
    checks++; if (bus.data_req !== 1'b1) begin errors++; $display("FAIL lw_req: got %b want 1", bus.data_req); end
    checks++; if (bus.data_addr !== 32'h80000010) begin errors++; $display("FAIL lw_addr: got %h want 80000010", bus.data_addr); end
    checks++; if ({bus.data_wr, bus.data_size} !== 3'b0_10) begin errors++; $display("FAIL lw_wr_size: got %b want 010", {bus.data_wr, bus.data_size}); end
    checks++; if (m_done !== 1'b0) begin errors++; $display("FAIL lw_early_done: got %b want 0", m_done); end
    bus.data_addr_ok = 1'b1; bus.data_data_ok = 1'b1; bus.data_rdata = 32'h12345678;
    @(negedge clk);  // DONE, third cycle
    bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0; bus.data_rdata = '0;
    checks++; if (m_done !== 1'b1) begin errors++; $display("FAIL lw_done: got %b want 1", m_done); end
    checks++; if (m_rdata !== 32'h12345678) begin errors++; $display("FAIL lw_rdata: got %h want 12345678", m_rdata); end
    checks++; if (m_stall !== 1'b0) begin errors++; $display("FAIL lw_done_stall: got %b want 0", m_stall); end
    @(negedge clk);
    checks++; if (m_done !== 1'b0) begin errors++; $display("FAIL lw_done_pulse: got %b want 0", m_done); end
    last_rdata = 32'h12345678;
    $display("txn LW addr=80000010 rdata=%h", m_rdata);
  endtask

  task automatic test_load_ext();
    mem_op_t     ops   [5] = '{MOP_LB, MOP_LBU, MOP_LHU, MOP_LH, MOP_LB};
    logic [31:0] addrs [5] = '{32'h80000013, 32'h80000013, 32'h80000012, 32'h80000012, 32'h80000010};
    logic [31:0] raws  [5] = '{32'h80FFFFFF, 32'h80FFFFFF, 32'h80FFFFFF, 32'h80FFFFFF, 32'h80FFFF7F};
    logic [31:0] exps  [5] = '{32'hFFFFFF80, 32'h00000080, 32'h000080FF, 32'hFFFF80FF, 32'h0000007F};
    logic [1:0]  sizes [5] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd0};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      m_valid = 1'b1; m_mem_op = ops[i]; m_addr = addrs[i];
      @(negedge clk);
      m_valid = 1'b0; m_mem_op = MOP_NONE;
      checks++; if (bus.data_size !== sizes[i]) begin errors++; $display("FAIL ext%0d_size: got %0d want %0d", i, bus.data_size, sizes[i]); end
      bus.data_addr_ok = 1'b1; bus.data_data_ok = 1'b1; bus.data_rdata = raws[i];
      @(negedge clk);
      bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0;
      checks++; if (m_done !== 1'b1) begin errors++; $display("FAIL ext%0d_done: got %b want 1", i, m_done); end
      checks++; if (m_rdata !== exps[i]) begin errors++; $display("FAIL ext%0d_rdata: got %h want %h", i, m_rdata, exps[i]); end
      last_rdata = exps[i];
      $display("txn load%0d addr=%h raw=%h rdata=%h", i, addrs[i], raws[i], m_rdata);
    end
  endtask

  task automatic test_store();
    mem_op_t     ops   [3] = '{MOP_SH, MOP_SB, MOP_SW};
    logic [31:0] addrs [3] = '{32'h80000002, 32'h80000001, 32'h80000004};
    logic [31:0] wds   [3] = '{32'hAAAABEEF, 32'h123456C3, 32'hDEADBEEF};
    logic [31:0] exps  [3] = '{32'hBEEFBEEF, 32'hC3C3C3C3, 32'hDEADBEEF};
    logic [1:0]  sizes [3] = '{2'd1, 2'd0, 2'd2};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      m_valid = 1'b1; m_mem_op = ops[i]; m_addr = addrs[i]; m_wdata = wds[i];
      @(negedge clk);
      m_valid = 1'b0; m_mem_op = MOP_NONE; m_addr = '0; m_wdata = '0;
      checks++; if (bus.data_wr !== 1'b1) begin errors++; $display("FAIL st%0d_wr: got %b want 1", i, bus.data_wr); end
      checks++; if (bus.data_size !== sizes[i]) begin errors++; $display("FAIL st%0d_size: got %0d want %0d", i, bus.data_size, sizes[i]); end
      checks++; if (bus.data_wdata !== exps[i]) begin errors++; $display("FAIL st%0d_wdata: got %h want %h", i, bus.data_wdata, exps[i]); end
      checks++; if (bus.data_addr !== addrs[i]) begin errors++; $display("FAIL st%0d_addr: got %h want %h", i, bus.data_addr, addrs[i]); end
      bus.data_addr_ok = 1'b1;
      @(negedge clk);  // WAIT
      bus.data_addr_ok = 1'b0;
      checks++; if ({bus.data_req, m_stall} !== 2'b01) begin errors++; $display("FAIL st%0d_wait: got req/stall %b want 01", i, {bus.data_req, m_stall}); end
      bus.data_data_ok = 1'b1;
      @(negedge clk);
      bus.data_data_ok = 1'b0;
      checks++; if (m_done !== 1'b1) begin errors++; $display("FAIL st%0d_done: got %b want 1", i, m_done); end
      checks++; if (m_rdata !== last_rdata) begin errors++; $display("FAIL st%0d_rdata_hold: got %h want %h", i, m_rdata, last_rdata); end
      $display("txn store%0d addr=%h wdata=%h", i, addrs[i], exps[i]);
    end
  endtask

  task automatic test_addr_err();
    mem_op_t     ops   [4] = '{MOP_LW, MOP_LH, MOP_SW, MOP_SH};
    logic [31:0] addrs [4] = '{32'h80000002, 32'h80000001, 32'h80000001, 32'h80000003};
    logic [1:0]  errs  [4] = '{2'b10, 2'b10, 2'b01, 2'b01};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      m_valid = 1'b1; m_mem_op = ops[i]; m_addr = addrs[i]; m_wdata = 32'h11111111;
      #1;
      checks++; if ({m_adel, m_ades} !== errs[i]) begin errors++; $display("FAIL err%0d_flags: got %b want %b", i, {m_adel, m_ades}, errs[i]); end
      checks++; if (m_badvaddr !== addrs[i]) begin errors++; $display("FAIL err%0d_badvaddr: got %h want %h", i, m_badvaddr, addrs[i]); end
      checks++; if (m_stall !== 1'b0) begin errors++; $display("FAIL err%0d_stall: got %b want 0", i, m_stall); end
      repeat (2) begin
        @(negedge clk);
        checks++; if (bus.data_req !== 1'b0) begin errors++; $display("FAIL err%0d_no_req: got %b want 0", i, bus.data_req); end
      end
      m_valid = 1'b0;
      #1;
      checks++; if ({m_adel, m_ades} !== 2'b00) begin errors++; $display("FAIL err%0d_invalid: got %b want 00", i, {m_adel, m_ades}); end
      $display("txn addr_err%0d addr=%h adel/ades=%b", i, addrs[i], errs[i]);
    end
    m_mem_op = MOP_NONE; m_addr = '0; m_wdata = '0;
  endtask

  task automatic test_delayed_ok();
    @(negedge clk);
    m_valid = 1'b1; m_mem_op = MOP_SW; m_addr = 32'h80000030; m_wdata = 32'h01020304;
    @(negedge clk);
    m_valid = 1'b0; m_mem_op = MOP_NONE; m_addr = '0; m_wdata = '0;
    for (int c = 0; c < 4; c++) begin
      checks++; if (bus.data_req !== 1'b1) begin errors++; $display("FAIL dly%0d_req: got %b want 1", c, bus.data_req); end
      checks++; if (bus.data_addr !== 32'h80000030) begin errors++; $display("FAIL dly%0d_addr: got %h want 80000030", c, bus.data_addr); end
      checks++; if (bus.data_wdata !== 32'h01020304) begin errors++; $display("FAIL dly%0d_wdata: got %h want 01020304", c, bus.data_wdata); end
      checks++; if ({m_stall, m_done} !== 2'b10) begin errors++; $display("FAIL dly%0d_stall_done: got %b want 10", c, {m_stall, m_done}); end
      if (c < 3) @(negedge clk);
    end
    bus.data_addr_ok = 1'b1; bus.data_data_ok = 1'b1;
    @(negedge clk);
    bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0;
    checks++; if ({m_done, m_stall} !== 2'b10) begin errors++; $display("FAIL dly_done: got done/stall %b want 10", {m_done, m_stall}); end
    $display("txn SW delayed addr_ok addr=80000030");
  endtask

  task automatic test_flush();
    // Flush in IDLE suppresses the issue entirely.
    @(negedge clk);
    m_valid = 1'b1; m_mem_op = MOP_LW; m_addr = 32'h80000040; m_flush = 1'b1;
    #1;
    checks++; if (m_stall !== 1'b0) begin errors++; $display("FAIL fl_idle_stall: got %b want 0", m_stall); end
    @(negedge clk);
    checks++; if (bus.data_req !== 1'b0) begin errors++; $display("FAIL fl_idle_req: got %b want 0", bus.data_req); end
    m_flush = 1'b0;
    // Now issue, reach WAIT, then flush and return data two cycles later.
    @(negedge clk);
    m_valid = 1'b0; m_mem_op = MOP_NONE; bus.data_addr_ok = 1'b1;
    @(negedge clk);  // WAIT
    bus.data_addr_ok = 1'b0; m_flush = 1'b1;
    #1;
    checks++; if (m_stall !== 1'b1) begin errors++; $display("FAIL fl_wait_stall: got %b want 1", m_stall); end
    @(negedge clk);
    m_flush = 1'b0;
    checks++; if (m_stall !== 1'b1) begin errors++; $display("FAIL fl_held_stall: got %b want 1", m_stall); end
    @(negedge clk);
    bus.data_data_ok = 1'b1; bus.data_rdata = 32'h55555555;
    @(negedge clk);
    bus.data_data_ok = 1'b0; bus.data_rdata = '0;
    checks++; if ({m_done, m_stall} !== 2'b00) begin errors++; $display("FAIL fl_absorb: got done/stall %b want 00", {m_done, m_stall}); end
    checks++; if (m_rdata !== last_rdata) begin errors++; $display("FAIL fl_rdata_hold: got %h want %h", m_rdata, last_rdata); end
    @(negedge clk);
    checks++; if (m_done !== 1'b0) begin errors++; $display("FAIL fl_late_done: got %b want 0", m_done); end
    // Next op goes through normally.
    m_valid = 1'b1; m_mem_op = MOP_LHU; m_addr = 32'h80000046;
    @(negedge clk);
    m_valid = 1'b0; m_mem_op = MOP_NONE;
    checks++; if (bus.data_req !== 1'b1) begin errors++; $display("FAIL fl_next_req: got %b want 1", bus.data_req); end
    bus.data_addr_ok = 1'b1; bus.data_data_ok = 1'b1; bus.data_rdata = 32'hA5C30000;
    @(negedge clk);
    bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0;
    checks++; if (m_done !== 1'b1) begin errors++; $display("FAIL fl_next_done: got %b want 1", m_done); end
    checks++; if (m_rdata !== 32'h0000A5C3) begin errors++; $display("FAIL fl_next_rdata: got %h want 0000a5c3", m_rdata); end
    last_rdata = 32'h0000A5C3;
    $display("txn flush in WAIT absorbed, next LHU rdata=%h", m_rdata);
  endtask

  task automatic test_idle_data_ok();
    @(negedge clk);
    bus.data_data_ok = 1'b1; bus.data_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    bus.data_data_ok = 1'b0;
    checks++; if (m_done !== 1'b0) begin errors++; $display("FAIL idle_ok_done: got %b want 0", m_done); end
    checks++; if (m_rdata !== last_rdata) begin errors++; $display("FAIL idle_ok_rdata: got %h want %h", m_rdata, last_rdata); end
    $display("txn stray data_ok in IDLE ignored");
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    m_valid = 1'b1; m_mem_op = MOP_LW; m_addr = 32'h80000050;
    @(negedge clk);
    m_valid = 1'b0; m_mem_op = MOP_NONE;
    checks++; if (bus.data_req !== 1'b1) begin errors++; $display("FAIL rmid_req: got %b want 1", bus.data_req); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if ({bus.data_req, m_stall} !== 2'b00) begin errors++; $display("FAIL rmid_idle: got req/stall %b want 00", {bus.data_req, m_stall}); end
    checks++; if (m_rdata !== 32'h0) begin errors++; $display("FAIL rmid_rdata: got %h want 0", m_rdata); end
    bus.data_data_ok = 1'b1; bus.data_rdata = 32'h99999999;
    @(negedge clk);
    bus.data_data_ok = 1'b0;
    checks++; if (m_done !== 1'b0) begin errors++; $display("FAIL rmid_done: got %b want 0", m_done); end
    $display("txn reset mid-transaction");
  endtask

  initial begin
    test_reset();
    test_lw();
    test_load_ext();
    test_store();
    test_addr_err();
    test_delayed_ok();
    test_flush();
    test_idle_data_ok();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
